// File: rtl/coeff_reconstruct_if.sv
// Handshake/data bundle between level decode, run decode and coeff_reconstruct.
//   master: upstream side; drives Start/TotalCoeff, levels, total_zeros and runs,
//           and observes RunReady plus the reconstructed coefficient stream.
//   slave : coeff_reconstruct side; the opposite directions.
// LW is the level/coefficient width (two's complement).
interface coeff_reconstruct_if #(
    parameter int unsigned LW = 13
);
    logic          Start;
    logic [4:0]    TotalCoeff;
    logic [LW-1:0] LevelIn;
    logic          LevelWr;
    logic [3:0]    TotalZeros;
    logic          TotalZerosWr;
    logic [3:0]    RunBefore;
    logic          RunWr;
    logic          RunReady;
    logic [LW-1:0] CoeffOut;
    logic [3:0]    CoeffIdx;
    logic          CoeffValid;
    logic          BlockDone;
    logic          Busy;
    logic          Err;

    modport master (
        output Start, TotalCoeff, LevelIn, LevelWr, TotalZeros, TotalZerosWr, RunBefore, RunWr,
        input  RunReady, CoeffOut, CoeffIdx, CoeffValid, BlockDone, Busy, Err
    );

    modport slave (
        input  Start, TotalCoeff, LevelIn, LevelWr, TotalZeros, TotalZerosWr, RunBefore, RunWr,
        output RunReady, CoeffOut, CoeffIdx, CoeffValid, BlockDone, Busy, Err
    );
endinterface

// File: rtl/coeff_reconstruct.sv
// CAVLC coefficient reconstruction for one 4x4 block.
// Buffers the signed levels (decode order, highest frequency first), then places
// them at their zig-zag scan positions using total_zeros and run_before, and
// streams the 16 coefficients out in scan order, index 0 first.
// Ports:
//   Clk    : clock
//   nReset : synchronous active-low reset
//   bus    : coeff_reconstruct_if.slave (block start, levels, total_zeros, runs in;
//            RunReady, CoeffOut/CoeffIdx/CoeffValid, BlockDone, Busy, Err out)
module coeff_reconstruct #(
    parameter int unsigned LW = 13,
    parameter int unsigned NC = 16
) (
    input  logic               Clk,
    input  logic               nReset,
    coeff_reconstruct_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StCollect, StPlace, StOutput} state_e;

    state_e        state;
    logic [4:0]    tc;
    logic [4:0]    levelCnt;
    logic [4:0]    placeCnt;
    logic [3:0]    pos;
    logic [3:0]    zerosLeft;
    logic          tzSeen;
    logic [LW-1:0] levelBuf [NC];
    logic [LW-1:0] coeff    [NC];

    logic [5:0] zeroSum;
    logic       overflow;
    logic [3:0] startPos;
    logic [3:0] startZeros;
    logic [3:0] run;
    logic       runClip;
    logic [3:0] nextPos;
    logic       collectGo;
    logic       placeGo;
    logic       placeLast;

    always_comb begin
        // In COLLECT, zerosLeft still holds the raw total_zeros.
        zeroSum    = {1'b0, tc} + {2'b00, zerosLeft};
        overflow   = zeroSum > 6'd16;
        startPos   = overflow ? 4'd15 : 4'(zeroSum - 6'd1);
        // Keep enough room below the top position for the remaining levels.
        startZeros = overflow ? 4'(5'd16 - tc) : zerosLeft;
        run        = (bus.RunBefore > zerosLeft) ? zerosLeft : bus.RunBefore;
        runClip    = (zerosLeft != 4'd0) && (bus.RunBefore > zerosLeft);
        nextPos    = pos - run - 4'd1;
        collectGo  = (state == StCollect) && (levelCnt == tc) && tzSeen;
        placeGo    = (state == StPlace) && ((zerosLeft == 4'd0) || bus.RunWr);
        placeLast  = (placeCnt + 5'd1) == tc;
    end

    assign bus.RunReady = (state == StPlace) && (zerosLeft != 4'd0);

    always_ff @(posedge Clk) begin
        if (!nReset) begin
            state          <= StIdle;
            tc             <= '0;
            levelCnt       <= '0;
            placeCnt       <= '0;
            pos            <= '0;
            zerosLeft      <= '0;
            tzSeen         <= 1'b0;
            for (int i = 0; i < NC; i++) begin
                levelBuf[i] <= '0;
                coeff[i]    <= '0;
            end
            bus.CoeffOut   <= '0;
            bus.CoeffIdx   <= '0;
            bus.CoeffValid <= 1'b0;
            bus.BlockDone  <= 1'b0;
            bus.Busy       <= 1'b0;
            bus.Err        <= 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (bus.Start) begin
                        tc        <= bus.TotalCoeff;
                        levelCnt  <= '0;
                        placeCnt  <= '0;
                        pos       <= '0;
                        zerosLeft <= '0;
                        tzSeen    <= 1'b0;
                        for (int i = 0; i < NC; i++) begin
                            levelBuf[i] <= '0;
                            coeff[i]    <= '0;
                        end
                        bus.Err  <= 1'b0;
                        bus.Busy <= 1'b1;
                        if (bus.TotalCoeff == 5'd0) begin
                            // Nothing to place: stream zeros immediately.
                            state          <= StOutput;
                            bus.CoeffValid <= 1'b1;
                            bus.CoeffIdx   <= '0;
                            bus.CoeffOut   <= '0;
                        end else begin
                            state <= StCollect;
                        end
                    end
                end

                StCollect: begin
                    if (bus.LevelWr) begin
                        if (levelCnt == tc) begin
                            bus.Err <= 1'b1;
                        end else begin
                            levelBuf[levelCnt[3:0]] <= bus.LevelIn;
                            levelCnt                <= levelCnt + 5'd1;
                        end
                    end
                    if (bus.TotalZerosWr) begin
                        zerosLeft <= bus.TotalZeros;
                        tzSeen    <= 1'b1;
                    end
                    if (collectGo) begin
                        pos             <= startPos;
                        zerosLeft       <= startZeros;
                        coeff[startPos] <= levelBuf[0];
                        placeCnt        <= 5'd1;
                        if (overflow) begin
                            bus.Err <= 1'b1;
                        end
                        if (tc == 5'd1) begin
                            // Output index 0 is loaded on the same edge as the placement.
                            state          <= StOutput;
                            bus.CoeffValid <= 1'b1;
                            bus.CoeffIdx   <= '0;
                            bus.CoeffOut   <= (startPos == 4'd0) ? levelBuf[0] : coeff[0];
                        end else begin
                            state <= StPlace;
                        end
                    end
                end

                StPlace: begin
                    if (placeGo) begin
                        pos            <= nextPos;
                        zerosLeft      <= zerosLeft - run;
                        coeff[nextPos] <= levelBuf[placeCnt[3:0]];
                        placeCnt       <= placeCnt + 5'd1;
                        if (runClip) begin
                            bus.Err <= 1'b1;
                        end
                        if (placeLast) begin
                            state          <= StOutput;
                            bus.CoeffValid <= 1'b1;
                            bus.CoeffIdx   <= '0;
                            bus.CoeffOut   <= (nextPos == 4'd0) ? levelBuf[placeCnt[3:0]]
                                                                : coeff[0];
                        end
                    end
                end

                StOutput: begin
                    if (bus.CoeffIdx == 4'd15) begin
                        state          <= StIdle;
                        bus.CoeffValid <= 1'b0;
                        bus.BlockDone  <= 1'b0;
                        bus.CoeffIdx   <= '0;
                        bus.CoeffOut   <= '0;
                        bus.Busy       <= 1'b0;
                    end else begin
                        bus.CoeffIdx  <= bus.CoeffIdx + 4'd1;
                        bus.CoeffOut  <= coeff[bus.CoeffIdx + 4'd1];
                        bus.BlockDone <= (bus.CoeffIdx == 4'd14);
                    end
                end

                default: state <= StIdle;
            endcase
        end
    end
endmodule
